// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package arb_pkg;
    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/encoder8x3_behav.sv
// One-hot (or lowest-priority-wins) 8-to-3 binary encoder; all-zero input encodes to 0.
// Latency: combinational.
// Backpressure: none.
module encoder8x3_behav (
    input  logic [7:0] in_oh,
    output logic [2:0] out_idx
);
    always_comb begin
        out_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_oh[i]) out_idx = 3'(i);
        end
    end
endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request scanning from ptr upward, wrapping at 7.
// Latency: combinational.
// Backpressure: none.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_oh,
    output logic             pick_any
);
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]   rot_oh;
    logic [2*N_REQ-1:0] oh_dbl;

    // Rotate so requester ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl  = {req, req} >> ptr;
        req_rot  = req_dbl[N_REQ-1:0];
        rot_oh   = req_rot & (~req_rot + N_REQ'(1));
        oh_dbl   = {rot_oh, rot_oh} << ptr;
        pick_oh  = oh_dbl[2*N_REQ-1:N_REQ];
        pick_any = |req;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, index and hold limit.
// Latency: grant registered one edge after request sampled in IDLE; one idle cycle between grants.
// Backpressure: holder keeps the resource until gnt_release, dropped req, or MAX_HOLD expiry.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    // "release" is a reserved word in SystemVerilog, hence gnt_release.
    input  logic             gnt_release,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);
    localparam bit              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;

    logic [N_REQ-1:0]   pick_oh;
    logic               pick_any;
    logic [IDX_W-1:0]   enc_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic               holder_req;
    logic               limit_hit;
    logic               end_cond;

    rr_pick8 u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .pick_oh  (pick_oh),
        .pick_any (pick_any)
    );

    encoder8x3_behav u_enc (
        .in_oh   (pick_oh),
        .out_idx (enc_idx)
    );

    always_comb begin
        pick_idx   = pick_any ? enc_idx : '0;
        holder_req = req[gnt_idx_q];
        limit_hit  = HOLD_EN && (hold_cnt_q == HOLD_LAST);
        end_cond   = gnt_release || !holder_req || limit_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = GRANT;
            GRANT:   if (end_cond) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d       = pick_oh;
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (end_cond) begin
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + IDX_W'(1);
                    // Only flag a timeout when the limit alone ended the grant.
                    timeout_d   = limit_hit && !gnt_release && holder_req;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        gnt_idx   = gnt_idx_q;
        gnt_valid = gnt_valid_q;
        timeout   = timeout_q;
    end
endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: behavioural round-robin model checked every cycle, plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_arbiter8;
    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       gnt_release = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: granted requester (-1 when idle), search start, cycles held, timeout flag.
    int m_idx  = -1;
    int m_ptr  = 0;
    int m_hold = 0;
    bit m_to   = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .gnt_release (gnt_release),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        bit lim;
        bit found;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_idx = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
        end else if (m_idx < 0) begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && req[(m_ptr + k) % 8]) begin
                    m_idx  = (m_ptr + k) % 8;
                    m_hold = 0;
                    found  = 1'b1;
                end
            end
        end else begin
            lim = (MAXH != 0) && (m_hold == MAXH - 1);
            if (gnt_release || !req[m_idx] || lim) begin
                m_to  = lim && !gnt_release && req[m_idx];
                m_ptr = (m_idx + 1) % 8;
                m_idx = -1;
            end else begin
                m_hold = (m_hold < 255) ? m_hold + 1 : 255;
                m_to   = 1'b0;
            end
        end
    end

    initial forever begin
        logic [7:0] e_gnt;
        logic [2:0] e_idx;
        @(negedge clk);
        e_gnt = (m_idx < 0) ? 8'h00 : (8'h01 << m_idx);
        e_idx = (m_idx < 0) ? 3'd0 : 3'(m_idx);
        check("model_gnt",     32'(gnt),       32'(e_gnt));
        check("model_gnt_idx", 32'(gnt_idx),   32'(e_idx));
        check("model_valid",   32'(gnt_valid), 32'(m_idx >= 0));
        check("model_timeout", 32'(timeout),   32'(m_to));
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_gnt",     32'(gnt),       0);
        check("rst_valid",   32'(gnt_valid), 0);
        check("rst_timeout", 32'(timeout),   0);
        rst_n = 1'b1;

        // Single requester, then drop.
        req = 8'h10;
        @(negedge clk);
        check("a_gnt",   32'(gnt),       32'h10);
        check("a_idx",   32'(gnt_idx),   4);
        check("a_valid", 32'(gnt_valid), 1);
        req = 8'h00;
        @(negedge clk);
        check("a_drop_gnt",   32'(gnt),       0);
        check("a_drop_valid", 32'(gnt_valid), 0);
        check("a_model_ptr",  32'(m_ptr),     5);

        // Wrapped search from ptr=5.
        req = 8'h09;
        @(negedge clk);
        check("wrap_idx", 32'(gnt_idx), 0);
        gnt_release = 1'b1;
        @(negedge clk);
        check("wrap_gap", 32'(gnt_valid), 0);
        gnt_release = 1'b0;
        @(negedge clk);
        check("wrap_next_idx", 32'(gnt_idx), 3);
        gnt_release = 1'b1;
        @(negedge clk);
        gnt_release = 1'b0;
        req = 8'h00;
        @(negedge clk);

        // Full rotation from ptr=0, including 7 -> 0 wrap.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("rot_idx",   32'(gnt_idx),   32'(i % 8));
            check("rot_valid", 32'(gnt_valid), 1);
            gnt_release = 1'b1;
            @(negedge clk);
            check("rot_gap", 32'(gnt_valid), 0);
            gnt_release = 1'b0;
        end
        req = 8'h00;
        @(negedge clk);

        // Hold limit with a single persistent requester.
        req = 8'h04;
        n = 0;
        @(negedge clk);
        while (gnt_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("to_len",   32'(n),       MAXH);
        check("to_pulse", 32'(timeout), 1);
        @(negedge clk);
        check("to_regrant_idx",   32'(gnt_idx),   2);
        check("to_regrant_valid", 32'(gnt_valid), 1);
        check("to_pulse_cleared", 32'(timeout),   0);

        // Release coincides with the limit.
        repeat (3) @(negedge clk);
        gnt_release = 1'b1;
        @(negedge clk);
        check("co_valid",   32'(gnt_valid), 0);
        check("co_timeout", 32'(timeout),   0);
        gnt_release = 1'b0;
        req = 8'h00;
        @(negedge clk);

        // Asynchronous reset in the middle of a grant.
        req = 8'h40;
        @(negedge clk);
        check("r6_idx", 32'(gnt_idx), 6);
        #3 rst_n = 1'b0;
        #1;
        check("arst_gnt",     32'(gnt),       0);
        check("arst_idx",     32'(gnt_idx),   0);
        check("arst_valid",   32'(gnt_valid), 0);
        check("arst_timeout", 32'(timeout),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'hC0;
        @(negedge clk);
        check("post_rst_idx", 32'(gnt_idx), 6);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) req = 8'($urandom);
                else req = 8'($urandom) & 8'($urandom) & 8'($urandom);
            end
            gnt_release = ($urandom_range(0, 7) == 0);
        end
        gnt_release = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
